// File: rtl/key_pio_pkg.sv
// Shared constants for the key/switch input PIO: register word addresses,
// edge-capture mode encodings and the debounce counter width helper.
package key_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RAW     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Width of a counter that must reach n-1; at least one bit so that
  // DEBOUNCE_CYCLES=1 still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_pio_irq_if.sv
// Avalon-MM slave bus bundle for the key PIO. Single-cycle writes, reads
// with a fixed latency of one clock; there is no waitrequest.
// Handshake: a write takes effect on any rising clk edge where
// chipselect=1 and write_n=0; readdata always shows, one clock later, the
// register selected by address (reads need no strobe and have no effect).
interface key_pio_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/key_pio_debounce_chan.sv
// One input channel: a flop synchroniser followed by a counter debouncer.
// rise_o/fall_o are asserted during the cycle whose clock edge loads the
// new value into stable_o, so a consumer registering them lines up with
// the stable change.
module key_pio_debounce_chan
  import key_pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_i,
  output logic sync_o,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   sync;
  logic                   changed;
  logic                   accept;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign changed = (sync != stable_q);
  assign accept  = changed && (cnt_q == CNT_LAST);

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
  end

  // Count consecutive cycles of disagreement; any agreement restarts the
  // count, so a glitch can never accumulate across bounces. The counter
  // is cleared on acceptance and therefore never wraps.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (!changed) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d    = '0;
      stable_d = sync;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign sync_o   = sync;
  assign stable_o = stable_q;
  assign rise_o   = accept & sync;
  assign fall_o   = accept & ~sync;

endmodule

// File: rtl/key_pio_irq.sv
// Avalon-MM input PIO for push-buttons/switches: per-channel synchroniser
// and debounce, edge capture with write-1-to-clear, per-bit interrupt mask
// and a level interrupt built only from registered state.
module key_pio_irq
  import key_pio_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  key_pio_irq_if.slave     bus,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_set;

  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             wr_en;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    key_pio_debounce_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .in_i    (in_port[i]),
      .sync_o  (sync[i]),
      .stable_o(stable[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i])
    );
  end

  if (EDGE_MODE == EDGE_FALL) begin : g_edge_fall
    assign edge_set = fall;
  end else if (EDGE_MODE == EDGE_ANY) begin : g_edge_any
    assign edge_set = rise | fall;
  end else begin : g_edge_rise
    assign edge_set = rise;
  end

  assign wr_en = bus.chipselect & ~bus.write_n;

  // Upper write-data bits have no storage behind them.
  assign unused_wdata = ^bus.writedata;

  // Next-state for mask and capture; a new edge is OR-ed in after the
  // clear so that a simultaneous set beats the write-1-to-clear.
  always_comb begin
    irqmask_d = irqmask_q;
    edgecap_d = edgecap_q;
    if (wr_en && (bus.address == ADDR_IRQMASK)) begin
      irqmask_d = bus.writedata[WIDTH-1:0];
    end
    if (wr_en && (bus.address == ADDR_EDGECAP)) begin
      edgecap_d = edgecap_q & ~bus.writedata[WIDTH-1:0];
    end
    edgecap_d = edgecap_d | edge_set;
  end

  // Read mux for the current address, zero-extended to the bus width.
  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = stable;
      ADDR_RAW:     readdata_d[WIDTH-1:0] = sync;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
      default:      readdata_d = '0;
    endcase
  end

  // Register file and registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q  <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      irqmask_q  <= irqmask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_key_pio_irq.sv
// Directed bench for key_pio_irq with WIDTH=2, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, rising-edge capture. Inputs are driven and outputs
// sampled on the falling clock edge; expected values go into exp_q when a
// step is issued and are popped when the matching output is sampled.
module tb_key_pio_irq;
  import key_pio_pkg::*;

  localparam int W = 32;

  logic       clk;
  logic       reset_n;
  logic [1:0] in_port;
  logic       irq;

  key_pio_irq_if bus ();

  logic [W-1:0] exp_q[$];
  int           n_tests;
  int           n_fail;

  key_pio_irq #(
    .WIDTH          (2),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .EDGE_MODE      (0)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave),
    .in_port(in_port),
    .irq    (irq)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard compare: pop the oldest expectation and check it.
  task automatic check(input string tag, input logic [W-1:0] got);
    logic [W-1:0] exp;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h expected <empty queue>", tag, got);
    end else begin
      exp = exp_q.pop_front();
      assert (got === exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
    end
  endtask

  // Select a register, wait one clock of read latency, compare readdata.
  task automatic expect_rd(input string tag, input logic [1:0] addr,
                           input logic [W-1:0] e);
    bus.address = addr;
    exp_q.push_back(e);
    @(negedge clk);
    check(tag, bus.readdata);
  endtask

  // Compare irq right now.
  task automatic expect_irq(input string tag, input logic e);
    exp_q.push_back({31'b0, e});
    check(tag, {31'b0, irq});
  endtask

  // Drive in_port for one clock, then compare DATA.
  task automatic drive_chk(input string tag, input logic [1:0] in_val,
                           input logic [W-1:0] e);
    in_port     = in_val;
    bus.address = ADDR_DATA;
    exp_q.push_back(e);
    @(negedge clk);
    check(tag, bus.readdata);
  endtask

  // Single-cycle Avalon write.
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    reset_n        = 1'b0;
    in_port        = 2'b11;
    bus.address    = ADDR_DATA;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // 1. Reset: outputs held at zero, then both keys settle 6 cycles after release
    idle(3);
    exp_q.push_back('0);
    check("reset_readdata", bus.readdata);
    expect_irq("reset_irq", 1'b0);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) expect_rd("release_data_low", ADDR_DATA, 32'h0);
    expect_rd("release_data_high", ADDR_DATA, 32'h3);

    in_port = 2'b00;
    idle(12);
    bus_write(ADDR_EDGECAP, 32'h3);
    expect_rd("edgecap_cleared", ADDR_EDGECAP, 32'h0);
    expect_rd("data_released", ADDR_DATA, 32'h0);

    // 2. Bounce on ch0: 3 high, 1 low, then steady high
    for (int k = 0; k < 3; k++) drive_chk("bounce_hi", 2'b01, 32'h0);
    drive_chk("bounce_lo", 2'b00, 32'h0);
    for (int k = 0; k < 6; k++) drive_chk("bounce_settling", 2'b01, 32'h0);
    drive_chk("bounce_settled", 2'b01, 32'h1);
    expect_rd("bounce_edgecap", ADDR_EDGECAP, 32'h1);

    // 3. IRQ raised by a masked-in rising edge, dropped by W1C
    bus_write(ADDR_EDGECAP, 32'h1);
    expect_rd("w1c_clears", ADDR_EDGECAP, 32'h0);
    bus_write(ADDR_IRQMASK, 32'h1);
    expect_irq("mask_only_no_irq", 1'b0);
    in_port = 2'b00;
    idle(10);
    in_port = 2'b01;
    idle(10);
    expect_irq("irq_on_edge", 1'b1);
    expect_rd("edgecap_before_clear", ADDR_EDGECAP, 32'h1);
    bus_write(ADDR_EDGECAP, 32'h1);
    expect_irq("irq_after_clear", 1'b0);
    expect_rd("edgecap_after_clear", ADDR_EDGECAP, 32'h0);

    // 4. Masked-off capture, then unmask raises irq next cycle
    bus_write(ADDR_IRQMASK, 32'h0);
    in_port = 2'b11;
    idle(10);
    expect_rd("ch1_captured", ADDR_EDGECAP, 32'h2);
    expect_irq("masked_no_irq", 1'b0);
    bus_write(ADDR_IRQMASK, 32'h2);
    expect_irq("unmask_irq", 1'b1);
    expect_rd("mask_readback", ADDR_IRQMASK, 32'h2);

    // 5. Capture set and W1C clear on the same edge: set wins
    bus_write(ADDR_EDGECAP, 32'h3);
    expect_irq("irq_cleared_ch1", 1'b0);
    in_port = 2'b10;
    idle(10);
    in_port = 2'b11;
    idle(5);
    bus_write(ADDR_EDGECAP, 32'h1);
    expect_rd("set_beats_clear", ADDR_EDGECAP, 32'h1);

    // 6. Falling edge does not capture; DATA/RAW ignore writes
    bus_write(ADDR_EDGECAP, 32'h3);
    in_port = 2'b10;
    idle(10);
    expect_rd("fall_data", ADDR_DATA, 32'h2);
    expect_rd("fall_no_capture", ADDR_EDGECAP, 32'h0);
    in_port = 2'b00;
    idle(10);
    bus_write(ADDR_DATA, 32'hFFFF_FFFF);
    expect_rd("data_write_ignored", ADDR_DATA, 32'h0);
    bus_write(ADDR_RAW, 32'hFFFF_FFFF);
    expect_rd("raw_write_ignored", ADDR_RAW, 32'h0);
    bus_write(ADDR_IRQMASK, 32'hFFFF_FFFF);
    expect_rd("mask_upper_zero", ADDR_IRQMASK, 32'h3);
    expect_irq("mask_all_no_capture", 1'b0);

    // RAW follows the synchroniser while DATA is still debouncing
    in_port = 2'b01;
    idle(2);
    expect_rd("raw_leads", ADDR_RAW, 32'h1);
    expect_rd("data_lags", ADDR_DATA, 32'h0);
    idle(10);
    expect_rd("late_capture", ADDR_EDGECAP, 32'h1);
    expect_irq("late_irq", 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
